// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: the slice width and
// the sequencer state encoding.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder_cell.sv
// Combinational 4-bit ripple adder.  Each bit position generates its
// carry as the majority of a, b and the incoming carry.
module nibble_adder_cell
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
    end
  endgenerate

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per clock through a single shared
// adder cell, with a start/busy/done handshake toward the requester.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter  int NIBBLES = 4,
  parameter  int CNT_W   = 2,
  localparam int WIDTH   = NIBBLE_W * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out,
  output logic             Ovf
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               carry_reg, carry_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [WIDTH-1:0]   sum_reg, sum_next;
  logic               c_out_reg, c_out_next;
  logic               ovf_reg, ovf_next;

  logic [NIBBLE_W-1:0] a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] b_nib [NIBBLES];
  logic [NIBBLE_W-1:0] cell_s;
  logic                cell_cout;
  logic                last_nib;

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_slice
      assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
      assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  // The single cell is time-multiplexed: the counter picks this cycle's nibble.
  nibble_adder_cell u_cell (
    .a    (a_nib[cnt_reg]),
    .b    (b_nib[cnt_reg]),
    .cin  (carry_reg),
    .s    (cell_s),
    .cout (cell_cout)
  );

  assign last_nib = (cnt_reg == CNT_W'(NIBBLES - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    c_out_next = c_out_reg;
    ovf_next   = ovf_reg;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        done = (state_reg == ST_DONE);
        if (start) begin
          state_next = ST_RUN;
          a_next     = A;
          b_next     = B;
          carry_next = C_in;
          cnt_next   = '0;
          sum_next   = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        sum_next[cnt_reg*NIBBLE_W +: NIBBLE_W] = cell_s;
        carry_next = cell_cout;
        cnt_next   = cnt_reg + CNT_W'(1);
        if (last_nib) begin
          c_out_next = cell_cout;
          // Signed overflow: like-signed operands yielding a differently signed result.
          ovf_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                       (cell_s[NIBBLE_W-1] != a_reg[WIDTH-1]);
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      c_out_reg <= c_out_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign Sum   = sum_reg;
  assign C_out = c_out_reg;
  assign Ovf   = ovf_reg;

endmodule
